// File: rtl/sprite_motion_ctrl_if.sv
// Host load channel for sprite_motion_ctrl: valid/ready handshake carrying
// a new origin and velocity.
interface sprite_motion_ctrl_if;
    logic       load_valid;
    logic       load_ready;
    logic [9:0] load_x;
    logic [8:0] load_y;
    logic [3:0] load_dx;
    logic [3:0] load_dy;

    modport master (
        output load_valid, load_x, load_y, load_dx, load_dy,
        input  load_ready
    );

    modport slave (
        input  load_valid, load_x, load_y, load_dx, load_dy,
        output load_ready
    );
endinterface

// File: rtl/sprite_motion_ctrl.sv
// Per-frame sprite position/velocity controller: at the start of vertical blank it
// advances the sprite, bounces it off the screen edges and applies host loads.
module sprite_motion_ctrl #(
    parameter int unsigned SCREEN_W   = 640,
    parameter int unsigned SCREEN_H   = 480,
    parameter int unsigned SPRITE_WID = 40,
    parameter int unsigned SPRITE_HGT = 40,
    parameter int unsigned INIT_X     = 300,
    parameter int unsigned INIT_Y     = 220,
    parameter int          INIT_DX    = 2,
    parameter int          INIT_DY    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [9:0]           raster_x,
    input  logic [8:0]           raster_y,
    input  logic                 enable,
    input  logic                 show,
    sprite_motion_ctrl_if.slave  load,
    output logic [9:0]           sprite_origin_offset_x,
    output logic [8:0]           sprite_origin_offset_y,
    output logic                 visible,
    output logic                 frame_done,
    output logic [7:0]           bounce_count,
    output logic                 corner
);

    localparam int unsigned XMAX = SCREEN_W - SPRITE_WID;
    localparam int unsigned YMAX = SCREEN_H - SPRITE_HGT;
    localparam logic signed [10:0] XMAX_S = 11'(XMAX);
    localparam logic signed [10:0] YMAX_S = 11'(YMAX);

    typedef enum logic [1:0] {StIdle, StUpdX, StUpdY} state_e;

    state_e      state_q, state_d;
    logic        frame_cond, frame_cond_q, frame_strobe;
    logic [9:0]  x_q, x_d;
    logic [8:0]  y_q, y_d;
    logic [3:0]  dx_q, dx_d, dy_q, dy_d;
    logic        vis_q, vis_d, done_q, done_d, corner_q, corner_d;
    logic [7:0]  bcnt_q, bcnt_d;
    logic        bounce_x_q, bounce_x_d, bounce_y;
    logic        pend_q, pend_d, use_pend_q, use_pend_d;
    logic [9:0]  pend_x_q, pend_x_d;
    logic [8:0]  pend_y_q, pend_y_d;
    logic [3:0]  pend_dx_q, pend_dx_d, pend_dy_q, pend_dy_d;
    logic        accept;
    logic signed [10:0] nx, ny;

    assign frame_cond   = (raster_y == 9'(SCREEN_H)) && (raster_x == '0);
    assign frame_strobe = frame_cond && !frame_cond_q;
    assign load.load_ready = !pend_q;
    assign accept       = load.load_valid && !pend_q;

    assign nx = $signed({1'b0, x_q}) + $signed({{7{dx_q[3]}}, dx_q});
    assign ny = $signed({2'b00, y_q}) + $signed({{7{dy_q[3]}}, dy_q});

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        dx_d       = dx_q;
        dy_d       = dy_q;
        vis_d      = vis_q;
        done_d     = 1'b0;
        corner_d   = 1'b0;
        bcnt_d     = bcnt_q;
        bounce_x_d = bounce_x_q;
        bounce_y   = 1'b0;
        use_pend_d = use_pend_q;
        pend_d     = pend_q;
        pend_x_d   = pend_x_q;
        pend_y_d   = pend_y_q;
        pend_dx_d  = pend_dx_q;
        pend_dy_d  = pend_dy_q;

        // Clamp at capture so the update path never sees out-of-range values.
        if (accept) begin
            pend_d    = 1'b1;
            pend_x_d  = (load.load_x > 10'(XMAX)) ? 10'(XMAX) : load.load_x;
            pend_y_d  = (load.load_y > 9'(YMAX)) ? 9'(YMAX) : load.load_y;
            pend_dx_d = (load.load_dx == 4'b1000) ? 4'b1001 : load.load_dx;
            pend_dy_d = (load.load_dy == 4'b1000) ? 4'b1001 : load.load_dy;
        end

        unique case (state_q)
            StIdle: begin
                if (frame_strobe) begin
                    state_d    = StUpdX;
                    // Snapshot so a load landing on the strobe waits a frame.
                    use_pend_d = pend_q;
                end
            end
            StUpdX: begin
                state_d    = StUpdY;
                bounce_x_d = 1'b0;
                if (use_pend_q) begin
                    x_d  = pend_x_q;
                    dx_d = pend_dx_q;
                end else if (enable) begin
                    if (nx[10]) begin
                        x_d        = '0;
                        dx_d       = 4'(-dx_q);
                        bounce_x_d = 1'b1;
                    end else if (nx > XMAX_S) begin
                        x_d        = 10'(XMAX);
                        dx_d       = 4'(-dx_q);
                        bounce_x_d = 1'b1;
                    end else begin
                        x_d = nx[9:0];
                    end
                end
            end
            StUpdY: begin
                state_d = StIdle;
                done_d  = 1'b1;
                vis_d   = show;
                if (use_pend_q) begin
                    y_d        = pend_y_q;
                    dy_d       = pend_dy_q;
                    pend_d     = 1'b0;
                    use_pend_d = 1'b0;
                end else if (enable) begin
                    if (ny[10]) begin
                        y_d      = '0;
                        dy_d     = 4'(-dy_q);
                        bounce_y = 1'b1;
                    end else if (ny > YMAX_S) begin
                        y_d      = 9'(YMAX);
                        dy_d     = 4'(-dy_q);
                        bounce_y = 1'b1;
                    end else begin
                        y_d = ny[8:0];
                    end
                end
                if ((bounce_x_q || bounce_y) && bcnt_q != 8'hff) begin
                    bcnt_d = bcnt_q + 8'd1;
                end
                corner_d = bounce_x_q && bounce_y;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            frame_cond_q <= 1'b0;
            x_q          <= 10'(INIT_X);
            y_q          <= 9'(INIT_Y);
            dx_q         <= 4'(INIT_DX);
            dy_q         <= 4'(INIT_DY);
            vis_q        <= 1'b0;
            done_q       <= 1'b0;
            corner_q     <= 1'b0;
            bcnt_q       <= '0;
            bounce_x_q   <= 1'b0;
            pend_q       <= 1'b0;
            use_pend_q   <= 1'b0;
            pend_x_q     <= '0;
            pend_y_q     <= '0;
            pend_dx_q    <= '0;
            pend_dy_q    <= '0;
        end else begin
            state_q      <= state_d;
            frame_cond_q <= frame_cond;
            x_q          <= x_d;
            y_q          <= y_d;
            dx_q         <= dx_d;
            dy_q         <= dy_d;
            vis_q        <= vis_d;
            done_q       <= done_d;
            corner_q     <= corner_d;
            bcnt_q       <= bcnt_d;
            bounce_x_q   <= bounce_x_d;
            pend_q       <= pend_d;
            use_pend_q   <= use_pend_d;
            pend_x_q     <= pend_x_d;
            pend_y_q     <= pend_y_d;
            pend_dx_q    <= pend_dx_d;
            pend_dy_q    <= pend_dy_d;
        end
    end

    assign sprite_origin_offset_x = x_q;
    assign sprite_origin_offset_y = y_q;
    assign visible                = vis_q;
    assign frame_done             = done_q;
    assign corner                 = corner_q;
    assign bounce_count           = bcnt_q;

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Scoreboard bench for sprite_motion_ctrl: each frame pushes its expected result,
// a monitor pops and compares on every frame_done pulse.
module tb_sprite_motion_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] raster_x;
    logic [8:0] raster_y;
    logic       enable, show;
    logic [9:0] ox;
    logic [8:0] oy;
    logic       visible, frame_done, corner;
    logic [7:0] bounce_count;

    sprite_motion_ctrl_if lif ();

    sprite_motion_ctrl dut (
        .clk                    (clk),
        .rst                    (rst),
        .raster_x               (raster_x),
        .raster_y               (raster_y),
        .enable                 (enable),
        .show                   (show),
        .load                   (lif.slave),
        .sprite_origin_offset_x (ox),
        .sprite_origin_offset_y (oy),
        .visible                (visible),
        .frame_done             (frame_done),
        .bounce_count           (bounce_count),
        .corner                 (corner)
    );

    always #5 clk = ~clk;

    typedef struct {
        int x;
        int y;
        int vis;
        int cor;
        int bcnt;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_frames = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && frame_done) begin
            n_frames++;
            check("frame_expected", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                check("frame_x", int'(ox), mon_e.x);
                check("frame_y", int'(oy), mon_e.y);
                check("frame_visible", int'(visible), mon_e.vis);
                check("frame_corner", int'(corner), mon_e.cor);
                check("frame_bounce_count", int'(bounce_count), mon_e.bcnt);
            end
        end
        if (!rst && corner) check("corner_with_done", int'(frame_done), 1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One frame strobe with raster held for 'hold' cycles; optionally checks X at
    // strobe+1 and raises a load in the strobe cycle.
    task automatic do_frame(input int hold, input int mid_x, input int ld, input exp_t e);
        exp_q.push_back(e);
        raster_x = '0;
        raster_y = 9'd480;
        lif.load_valid = ld[0];
        for (int i = 0; i < 7; i++) begin
            if (i == hold) raster_y = '0;
            tick();
            lif.load_valid = 1'b0;
            if (i == 1 && mid_x >= 0) check("x_at_strobe_plus1", int'(ox), mid_x);
        end
    endtask

    task automatic do_load(input logic [9:0] x, input logic [8:0] y,
                           input logic [3:0] dx, input logic [3:0] dy);
        check("load_ready_before_load", int'(lif.load_ready), 1);
        lif.load_x     = x;
        lif.load_y     = y;
        lif.load_dx    = dx;
        lif.load_dy    = dy;
        lif.load_valid = 1'b1;
        tick();
        lif.load_valid = 1'b0;
        check("load_ready_after_accept", int'(lif.load_ready), 0);
    endtask

    int f0;

    initial begin
        rst            = 1'b1;
        raster_x       = '0;
        raster_y       = '0;
        enable         = 1'b1;
        show           = 1'b1;
        lif.load_valid = 1'b0;
        lif.load_x     = '0;
        lif.load_y     = '0;
        lif.load_dx    = '0;
        lif.load_dy    = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("reset_x", int'(ox), 300);
        check("reset_y", int'(oy), 220);
        check("reset_visible", int'(visible), 0);
        check("reset_bounce_count", int'(bounce_count), 0);
        check("reset_load_ready", int'(lif.load_ready), 1);
        check("reset_frame_done", int'(frame_done), 0);
        check("reset_corner", int'(corner), 0);

        // Plain motion from reset velocity
        do_frame(1, 302, 0, '{302, 221, 1, 0, 0});

        // Right-edge bounce
        do_load(10'd598, 9'd100, 4'd5, 4'd0);
        do_frame(1, 598, 0, '{598, 100, 1, 0, 0});
        check("load_ready_after_apply", int'(lif.load_ready), 1);
        do_frame(1, 600, 0, '{600, 100, 1, 0, 1});
        do_frame(1, 595, 0, '{595, 100, 1, 0, 1});

        // Corner bounce
        do_load(10'd1, 9'd1, 4'hd, 4'hd);
        do_frame(1, 1, 0, '{1, 1, 1, 0, 1});
        do_frame(1, 0, 0, '{0, 0, 1, 1, 2});
        do_frame(1, 3, 0, '{3, 3, 1, 0, 2});

        // Load clamping
        do_load(10'd700, 9'd500, 4'h8, 4'h0);
        do_frame(1, 600, 0, '{600, 440, 1, 0, 2});
        check("load_ready_after_clamp_apply", int'(lif.load_ready), 1);
        do_frame(1, 593, 0, '{593, 440, 1, 0, 2});

        // Motion frozen, load still applies
        enable = 1'b0;
        f0 = n_frames;
        do_frame(1, 593, 0, '{593, 440, 1, 0, 2});
        do_load(10'd10, 9'd20, 4'd1, 4'd1);
        do_frame(1, 10, 0, '{10, 20, 1, 0, 2});
        show = 1'b0;
        do_frame(1, 10, 0, '{10, 20, 0, 0, 2});
        check("frozen_frame_count", n_frames - f0, 3);

        // Raster held for 5 cycles gives one update
        enable = 1'b1;
        show   = 1'b1;
        f0 = n_frames;
        do_frame(5, 11, 0, '{11, 21, 1, 0, 2});
        check("held_raster_frame_count", n_frames - f0, 1);

        // Load accepted on the strobe cycle waits a frame
        lif.load_x  = 10'd50;
        lif.load_y  = 9'd60;
        lif.load_dx = 4'hf;
        lif.load_dy = 4'hf;
        do_frame(1, 12, 1, '{12, 22, 1, 0, 2});
        check("load_ready_strobe_load_pending", int'(lif.load_ready), 0);
        do_frame(1, 50, 0, '{50, 60, 1, 0, 2});
        do_frame(1, 49, 0, '{49, 59, 1, 0, 2});

        // Reset mid-update discards state and pending load
        do_load(10'd5, 9'd5, 4'd0, 4'd0);
        raster_y = 9'd480;
        tick();
        tick();
        check("x_pending_applied_before_reset", int'(ox), 5);
        rst = 1'b1;
        #1;
        check("midreset_x", int'(ox), 300);
        check("midreset_y", int'(oy), 220);
        check("midreset_visible", int'(visible), 0);
        check("midreset_load_ready", int'(lif.load_ready), 1);
        check("midreset_bounce_count", int'(bounce_count), 0);
        raster_y = '0;
        tick();
        rst = 1'b0;
        repeat (3) tick();
        do_frame(1, 302, 0, '{302, 221, 1, 0, 0});

        repeat (3) tick();
        check("all_frames_seen", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sprite_motion_ctrl.md
Name: sprite_motion_ctrl

Overview:
Per-frame position and velocity controller for one 40x40 sprite. It drives the sprite origin offsets and the visible flag consumed by the sprite renderer. Once per frame, at the start of vertical blank, it advances the sprite by a signed velocity, bounces it off the screen edges and applies any pending host-loaded position or velocity. Because outputs change only during vertical blank, the active picture never tears.

Parameters:
SCREEN_W, 640, visible width in pixels
SCREEN_H, 480, visible height in lines
SPRITE_WID, 40, sprite width
SPRITE_HGT, 40, sprite height
INIT_X, 300, reset X origin
INIT_Y, 220, reset Y origin
INIT_DX, 2, reset X velocity (signed)
INIT_DY, 1, reset Y velocity (signed)

Ports:
CLK  in  1  system clock; single clock domain
RESET  in  1  asynchronous, active-high reset
RASTER_X  in  10  current raster column
RASTER_Y  in  9  current raster line
ENABLE  in  1  1 = move each frame; 0 = freeze motion
SHOW  in  1  requested visibility, sampled at frame update
LOAD_VALID  in  1  host load request
LOAD_READY  out  1  controller can accept a load
LOAD_X  in  10  load X origin
LOAD_Y  in  9  load Y origin
LOAD_DX  in  4  load X velocity, two's complement
LOAD_DY  in  4  load Y velocity, two's complement
SPRITE_ORIGIN_OFFSET_X  out  10  registered X origin
SPRITE_ORIGIN_OFFSET_Y  out  9  registered Y origin
VISIBLE  out  1  registered visible flag
FRAME_DONE  out  1  one-cycle pulse when the frame update completes
BOUNCE_COUNT  out  8  saturating count of frames containing any bounce
CORNER  out  1  one-cycle pulse, with FRAME_DONE, when X and Y bounce in the same frame

Behaviour:
- XMAX = SCREEN_W-SPRITE_WID (600); YMAX = SCREEN_H-SPRITE_HGT (440).
- Reset values: X=INIT_X, Y=INIT_Y, dx=INIT_DX, dy=INIT_DY, VISIBLE=0, FRAME_DONE=0, CORNER=0, BOUNCE_COUNT=0, LOAD_READY=1, no load pending, state IDLE.
- frame_strobe: the condition (RASTER_Y==SCREEN_H && RASTER_X==0) is true this cycle and was false last cycle. The strobe is rising-edge detected, so a raster held for several cycles gives one strobe.
- Load handshake: a load is accepted when LOAD_VALID && LOAD_READY.
  - On accept, the load fields go into a pending register and LOAD_READY drops to 0.
  - LOAD_READY returns to 1 in the cycle after the pending load is applied.
  - Pending values are clamped at capture: X>XMAX becomes XMAX; Y>YMAX becomes YMAX; velocity -8 becomes -7.
- States:
  - IDLE: on frame_strobe go to UPD_X, else stay.
  - UPD_X: update X and dx; go to UPD_Y.
  - UPD_Y: update Y and dy; latch VISIBLE<=SHOW; assert FRAME_DONE (and CORNER if applicable); go to IDLE.
  - A frame_strobe seen outside IDLE is ignored.
- Update rule when a load is pending: X, Y, dx and dy take the pending values (in UPD_X and UPD_Y respectively). There is no bounce, and ENABLE is ignored.
- Update rule when no load is pending and ENABLE=1, per axis, with 11-bit signed arithmetic n = pos + sext(d):
  - n<0: pos=0, d=-d, bounce.
  - n>MAX: pos=MAX, d=-d, bounce.
  - Otherwise pos=n.
- Update rule when no load is pending and ENABLE=0: position and velocity hold. VISIBLE and FRAME_DONE still update.
- Latency: X changes 1 cycle after the strobe; Y, VISIBLE and FRAME_DONE change 2 cycles after the strobe.
- BOUNCE_COUNT increments by 1 per frame in which either axis bounced, and saturates at 255. CORNER pulses when both axes bounced in that frame.
- A load accepted in the same cycle as frame_strobe is not used by that frame's update; it applies at the next frame.
- Reset asserted mid-update returns all state to reset values immediately; a pending load is discarded.
- Velocity is always held in the range -7..7, so negation never overflows.

Test Plan:
- Reset release, SHOW=1, one frame strobe: X=302 at strobe+1; Y=221, VISIBLE=1 and FRAME_DONE pulse at strobe+2.
- Right-edge bounce: load X=598, Y=100, dx=5, dy=0, then run 2 frames → first frame applies the load; second gives X=600, dx=-5, BOUNCE_COUNT=1, CORNER=0.
- Corner bounce: load X=1, Y=1, dx=-3, dy=-3, then run 2 frames → X=0, Y=0, dx=+3, dy=+3, BOUNCE_COUNT+1, CORNER pulse together with FRAME_DONE.
- Load clamping and handshake: load X=700, Y=500, dx=-8 → LOAD_READY=0 until the next frame; then X=600, Y=440, dx=-7 and LOAD_READY=1 again.
- ENABLE=0 for 3 frames → position unchanged; FRAME_DONE pulses 3 times; a load issued meanwhile is still applied.
- Raster held at (0,480) for 5 cycles → exactly one FRAME_DONE. RESET asserted at strobe+1 → X=300, Y=220, VISIBLE=0 immediately.
